pipe_traffic_engine: RTL and testbench

PIPE_TRAFFIC_ENGINE -- requirements
Module: pipe_traffic_engine

---
 rtl/pipe_traffic_engine.sv | 176 +++++++++++++++++
 tb/tb_pipe_traffic_engine.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_traffic_engine.sv
// Traffic generator/checker for a host FIFO loopback pipe: writes a pattern stream downstream
// and drains/counts the upstream stream. Define PIPE_TRAFFIC_CHECK_EN to build the data checker.
module pipe_traffic_engine #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              cfg_enable,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              gen_fifo_full,
  output logic              gen_fifo_wr_en,
  output logic [DATA_W-1:0] gen_fifo_din,
  input  logic              chk_fifo_empty,
  output logic              chk_fifo_rd_en,
  input  logic [DATA_W-1:0] chk_fifo_dout,
  input  logic              chk_fifo_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  gen_count,
  output logic [CNT_W-1:0]  chk_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  cyc_count,
  output logic [CNT_W-1:0]  first_err_idx
);

  localparam int unsigned NumLanes = DATA_W / 32;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state, w_state_nxt;
  logic               r_en_prev;
  logic               r_armed;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_len;
  logic [DATA_W-1:0]  r_gen_pat;
  logic [CNT_W-1:0]   r_gen_cnt, r_chk_cnt, r_cyc_cnt;
  logic               w_start, w_last, w_chk_take;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] pat_seed(input logic [1:0] mode);
    case (mode)
      2'd1:    pat_seed = {NumLanes{32'h0000_0001}};
      2'd2:    pat_seed = {(DATA_W / 4){4'h5}};
      default: pat_seed = '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] pat_next(input logic [1:0] mode,
                                                 input logic [DATA_W-1:0] cur);
    case (mode)
      2'd1:    pat_next = {NumLanes{lfsr_step(cur[31:0])}};
      2'd2:    pat_next = ~cur;
      default: pat_next = cur + DATA_W'(1);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  // r_armed blocks a run when cfg_enable is already high as reset releases.
  assign w_start    = (r_state == StIdle) && cfg_enable && !r_en_prev && r_armed;
  assign w_last     = (r_len != '0) && (r_gen_cnt == r_len - CNT_W'(1));
  assign w_chk_take = chk_fifo_valid && (r_state != StIdle);

  always_ff @(posedge sys_clk) begin
    if (!rstn) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_nxt = StRun;
      StRun: begin
        if (!cfg_enable)                  w_state_nxt = StIdle;
        else if (gen_fifo_wr_en && w_last) w_state_nxt = StDone;
      end
      StDone:  if (!cfg_enable) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    gen_fifo_wr_en = 1'b0;
    chk_fifo_rd_en = 1'b0;
    unique case (r_state)
      StRun: begin
        busy           = 1'b1;
        gen_fifo_wr_en = !gen_fifo_full;
        chk_fifo_rd_en = !chk_fifo_empty;
      end
      StDone: begin
        done           = 1'b1;
        chk_fifo_rd_en = !chk_fifo_empty;
      end
      default: ;
    endcase
  end

`ifdef PIPE_TRAFFIC_CHECK_EN
  logic [DATA_W-1:0] r_chk_pat;
  logic [CNT_W-1:0]  r_err_cnt, r_first_err;
  assign err_count     = r_err_cnt;
  assign first_err_idx = r_first_err;
`else
  logic w_unused_dout;
  assign w_unused_dout = ^chk_fifo_dout;
  assign err_count     = '0;
  assign first_err_idx = '1;
`endif

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_en_prev <= 1'b0;
      r_armed   <= ~cfg_enable;
      r_mode    <= '0;
      r_len     <= '0;
      r_gen_pat <= '0;
      r_gen_cnt <= '0;
      r_chk_cnt <= '0;
      r_cyc_cnt <= '0;
`ifdef PIPE_TRAFFIC_CHECK_EN
      r_chk_pat   <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '1;
`endif
    end else begin
      r_en_prev <= cfg_enable;
      r_armed   <= r_armed | ~cfg_enable;
      if (w_start) begin
        r_mode    <= cfg_mode;
        r_len     <= cfg_len;
        r_gen_pat <= pat_seed(cfg_mode);
        r_gen_cnt <= '0;
        r_chk_cnt <= '0;
        r_cyc_cnt <= '0;
`ifdef PIPE_TRAFFIC_CHECK_EN
        r_chk_pat   <= pat_seed(cfg_mode);
        r_err_cnt   <= '0;
        r_first_err <= '1;
`endif
      end else begin
        if (gen_fifo_wr_en) begin
          r_gen_pat <= pat_next(r_mode, r_gen_pat);
          r_gen_cnt <= sat_inc(r_gen_cnt);
        end
        if (r_state == StRun) r_cyc_cnt <= sat_inc(r_cyc_cnt);
        if (w_chk_take) begin
          r_chk_cnt <= sat_inc(r_chk_cnt);
`ifdef PIPE_TRAFFIC_CHECK_EN
          // Expected stream never resyncs to received data.
          r_chk_pat <= pat_next(r_mode, r_chk_pat);
          if (chk_fifo_dout != r_chk_pat) begin
            r_err_cnt <= sat_inc(r_err_cnt);
            if (r_err_cnt == '0) r_first_err <= r_chk_cnt;
          end
`endif
        end
      end
    end
  end

  assign gen_fifo_din = r_gen_pat;
  assign gen_count    = r_gen_cnt;
  assign chk_count    = r_chk_cnt;
  assign cyc_count    = r_cyc_cnt;

endmodule

// File: tb/tb_pipe_traffic_engine.sv
// Bench for pipe_traffic_engine: vector table of runs, scoreboard of generated words,
// FIFO loopback for the checker, plus directed reset and timing sequences.
`timescale 1ns/1ps
module tb_pipe_traffic_engine;
  localparam int DW = 128;
  localparam int CW = 32;

  logic          sys_clk = 1'b0;
  logic          rstn, cfg_enable, gen_fifo_full, gen_fifo_wr_en;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_len;
  logic [DW-1:0] gen_fifo_din, chk_fifo_dout;
  logic          chk_fifo_empty, chk_fifo_rd_en, chk_fifo_valid, busy, done;
  logic [CW-1:0] gen_count, chk_count, err_count, cyc_count, first_err_idx;

  pipe_traffic_engine #(.DATA_W(DW), .CNT_W(CW)) u_dut (
    .sys_clk(sys_clk), .rstn(rstn), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_len(cfg_len), .gen_fifo_full(gen_fifo_full), .gen_fifo_wr_en(gen_fifo_wr_en),
    .gen_fifo_din(gen_fifo_din), .chk_fifo_empty(chk_fifo_empty),
    .chk_fifo_rd_en(chk_fifo_rd_en), .chk_fifo_dout(chk_fifo_dout),
    .chk_fifo_valid(chk_fifo_valid), .busy(busy), .done(done), .gen_count(gen_count),
    .chk_count(chk_count), .err_count(err_count), .cyc_count(cyc_count),
    .first_err_idx(first_err_idx)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0] mode;
    int         len;
    int         ss;
    int         sl;
    int         eg;
    int         ec;
  } vec_t;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] lb_q[$];
  logic          mon_en = 1'b1;
  logic          lb_en = 1'b0;
  logic          idle_inj = 1'b0;
  logic          rd_fire = 1'b0;
  int            lb_idx = 0;
  int            corrupt_idx = -1;
  logic [DW-1:0] mon_w;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [DW-1:0] model_word(input logic [1:0] mode, input int idx);
    logic [31:0]   s;
    logic [DW-1:0] a;
    case (mode)
      2'd1: begin
        s = 32'h1;
        for (int i = 0; i < idx; i++) s = lfsr_next(s);
        a = {4{s}};
      end
      2'd2: begin
        a = {32{4'h5}};
        if (idx % 2 == 1) a = ~a;
      end
      default: a = DW'(idx);
    endcase
    return a;
  endfunction

  // Scoreboard monitor and loopback capture of every generated word.
  always @(negedge sys_clk) begin
    rd_fire = chk_fifo_rd_en;
    if (gen_fifo_wr_en) begin
      check("no_wr_while_full", gen_fifo_full, 1'b0);
      if (mon_en) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected_write: got %h, want no write", gen_fifo_din);
        end else begin
          mon_w = sb_q.pop_front();
          check("gen_word", gen_fifo_din, mon_w);
        end
      end
      if (lb_en) begin
        mon_w = gen_fifo_din;
        if (lb_idx == corrupt_idx) mon_w[0] = ~mon_w[0];
        lb_q.push_back(mon_w);
        lb_idx++;
      end
    end
  end

  // Upstream FIFO model: data valid the cycle after an accepted read strobe.
  always @(posedge sys_clk) begin
    #2;
    if (idle_inj) begin
      chk_fifo_valid = 1'b1;
      chk_fifo_dout  = '1;
    end else if (rd_fire && lb_q.size() > 0) begin
      chk_fifo_dout  = lb_q.pop_front();
      chk_fifo_valid = 1'b1;
    end else begin
      chk_fifo_valid = 1'b0;
    end
    chk_fifo_empty = !(lb_en && lb_q.size() > 0);
  end

  task automatic run_case(input vec_t v);
    int k;
    cfg_mode      = v.mode;
    cfg_len       = CW'(v.len);
    gen_fifo_full = 1'b0;
    for (int i = 0; i < v.len; i++) sb_q.push_back(model_word(v.mode, i));
    cfg_enable = 1'b1;
    step();
    k = 0;
    while (!done && k < 200) begin
      gen_fifo_full = (k >= v.ss) && (k < v.ss + v.sl);
      step();
      k++;
    end
    gen_fifo_full = 1'b0;
    check("run_done", done, 1'b1);
    check("gen_count", gen_count, v.eg);
    check("cyc_count", cyc_count, v.ec);
    check("busy_in_done", busy, 1'b0);
    check("sb_drained", sb_q.size(), 0);
    cfg_enable = 1'b0;
    step();
    check("idle_after_done", {busy, done}, 2'b00);
    check("gen_count_hold", gen_count, v.eg);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[6];
    int            k;
    logic [CW-1:0] exp_err, exp_first;
    vecs[0] = '{2'd0, 4, 0, 0, 4, 4};
    vecs[1] = '{2'd1, 2, 0, 0, 2, 2};
    vecs[2] = '{2'd2, 3, 0, 0, 3, 3};
    vecs[3] = '{2'd3, 5, 0, 0, 5, 5};
    vecs[4] = '{2'd0, 6, 2, 3, 6, 9};
    vecs[5] = '{2'd1, 1, 0, 1, 1, 2};

    rstn = 1'b0; cfg_enable = 1'b1; cfg_mode = 2'd0; cfg_len = '0; gen_fifo_full = 1'b0;
    chk_fifo_empty = 1'b1; chk_fifo_valid = 1'b0; chk_fifo_dout = '0;
    step(); step();
    check("rst_wr_en", gen_fifo_wr_en, 1'b0);
    check("rst_rd_en", chk_fifo_rd_en, 1'b0);
    check("rst_din", gen_fifo_din, '0);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_gen_count", gen_count, 0);
    check("rst_chk_count", chk_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_cyc_count", cyc_count, 0);
    check("rst_first_err", first_err_idx, {CW{1'b1}});

    // Enable held high through reset release must not start a run.
    rstn = 1'b1;
    repeat (5) step();
    check("hold_en_no_run", busy, 1'b0);
    check("hold_en_gen_count", gen_count, 0);
    cfg_enable = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_case(vecs[i]);

    // Counter run: words 0..3 on consecutive cycles right after the edge.
    mon_en = 1'b0; cfg_mode = 2'd0; cfg_len = 4; cfg_enable = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("d035_wr_en", gen_fifo_wr_en, 1'b1);
      check("d035_din", gen_fifo_din, DW'(i));
      step();
    end
    check("d035_done", done, 1'b1);
    check("d035_gen_count", gen_count, 4);
    check("d035_cyc_count", cyc_count, 4);
    cfg_enable = 1'b0;
    step();

    // LFSR run with literal expected words.
    cfg_mode = 2'd1; cfg_len = 2; cfg_enable = 1'b1;
    step();
    check("d036_wr0", gen_fifo_wr_en, 1'b1);
    check("d036_word0", gen_fifo_din, {4{32'h0000_0001}});
    step();
    check("d036_wr1", gen_fifo_wr_en, 1'b1);
    check("d036_word1", gen_fifo_din, {4{32'h8020_0003}});
    step();
    check("d036_done", done, 1'b1);
    check("d036_gen_count", gen_count, 2);
    cfg_enable = 1'b0;
    step();
    mon_en = 1'b1;

    // Loopback of 8 counter words, word 5 corrupted.
    lb_en = 1'b1; lb_idx = 0; corrupt_idx = 5;
    for (int i = 0; i < 8; i++) sb_q.push_back(model_word(2'd0, i));
    cfg_mode = 2'd0; cfg_len = 8; cfg_enable = 1'b1;
    step();
    k = 0;
    while (!(chk_count == 8 && done) && k < 100) begin
      step();
      k++;
    end
`ifdef PIPE_TRAFFIC_CHECK_EN
    exp_err = 1; exp_first = 5;
`else
    exp_err = 0; exp_first = '1;
`endif
    check("lb_chk_count", chk_count, 8);
    check("lb_err_count", err_count, exp_err);
    check("lb_first_err", first_err_idx, exp_first);
    cfg_enable = 1'b0;
    step();
    lb_en = 1'b0;
    idle_inj = 1'b1;
    step();
    idle_inj = 1'b0;
    step(); step();
    check("idle_valid_chk_count", chk_count, 8);
    check("idle_valid_err_count", err_count, exp_err);

    // Continuous alternating run for 1000 cycles.
    for (int i = 0; i < 1000; i++) sb_q.push_back(model_word(2'd2, i));
    cfg_mode = 2'd2; cfg_len = 0; cfg_enable = 1'b1;
    step();
    repeat (999) step();
    cfg_enable = 1'b0;
    step();
    check("cont_idle", {busy, done}, 2'b00);
    check("cont_gen_count", gen_count, 1000);
    check("cont_cyc_count", cyc_count, 1000);
    check("cont_sb_drained", sb_q.size(), 0);

    // Reset pulled mid-run.
    mon_en = 1'b0; cfg_mode = 2'd0; cfg_len = 0; cfg_enable = 1'b1;
    step(); step(); step();
    check("mid_busy", busy, 1'b1);
    rstn = 1'b0;
    step();
    check("mid_rst_wr_en", gen_fifo_wr_en, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_gen_count", gen_count, 0);
    check("mid_rst_cyc_count", cyc_count, 0);
    check("mid_rst_din", gen_fifo_din, '0);
    cfg_enable = 1'b0;
    rstn = 1'b1;
    step(); step();
    check("post_rst_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
